dvi_tx_config_seq: RTL and testbench

- Power-up register sequencer for the board's DVI transmitter. It walks a fixed table of register/value pairs and issues each one as a write transaction to the byte-level TWI write master.
- Sits between the system reset/PLL-lock logic and the TWI master.
- Its done flag gates release of the video reset, so the streamer starts only after the transmitter is configured.

---
 rtl/dvi_tx_cfg_pkg.sv | 23 ++
 rtl/dvi_tx_config_seq_if.sv | 32 +++
 rtl/dvi_tx_cfg_rom.sv | 22 ++
 rtl/dvi_tx_config_seq.sv | 146 ++++++++++++++
 tb/tb_dvi_tx_config_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvi_tx_cfg_pkg.sv
// Shared types and constants for the DVI transmitter power-up register sequencer.
package dvi_tx_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StIssue,
        StWait,
        StRetry,
        StNext,
        StDone,
        StFail
    } state_e;

    localparam int unsigned REG_COUNT = 5;
    localparam int unsigned IDX_W     = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REG_COUNT - 1);

    // 7-bit TWI slave address of the DVI transmitter
    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h76;

endpackage

// File: rtl/dvi_tx_config_seq_if.sv
// Write-request bus between the config sequencer (master) and the byte-level TWI write master.
interface dvi_tx_config_seq_if;

    logic       oWrValid;
    logic       iWrReady;
    logic [6:0] oWrDevAddr;
    logic [7:0] oWrRegAddr;
    logic [7:0] oWrData;
    logic       iWrDone;
    logic       iWrNack;

    modport master (
        output oWrValid,
        output oWrDevAddr,
        output oWrRegAddr,
        output oWrData,
        input  iWrReady,
        input  iWrDone,
        input  iWrNack
    );

    modport slave (
        input  oWrValid,
        input  oWrDevAddr,
        input  oWrRegAddr,
        input  oWrData,
        output iWrReady,
        output iWrDone,
        output iWrNack
    );

endinterface

// File: rtl/dvi_tx_cfg_rom.sv
// Fixed register/value table for the DVI transmitter; {reg, value} per index.
module dvi_tx_cfg_rom
    import dvi_tx_cfg_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [15:0]      entry_o
);

    // Table lookup; out-of-range indices read as zero
    always_comb begin
        entry_o = 16'h0000;
        case (idx_i)
            4'd0:    entry_o = 16'h49C0;
            4'd1:    entry_o = 16'h2109;
            4'd2:    entry_o = 16'h3308;
            4'd3:    entry_o = 16'h3416;
            4'd4:    entry_o = 16'h3660;
            default: entry_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvi_tx_config_seq.sv
// Power-up register sequencer: walks the config table and issues each entry as a TWI write,
// with startup delay, per-write timeout and bounded retries. oDone releases the video reset.
module dvi_tx_config_seq
    import dvi_tx_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR      = DEV_ADDR_DEFAULT,
    parameter logic [15:0] STARTUP_DELAY = 16'd50000,
    parameter logic [15:0] RETRY_DELAY   = 16'd1000,
    parameter logic [19:0] TIMEOUT       = 20'd200000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iStart,
    dvi_tx_config_seq_if.master  wr,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oError,
    output logic [IDX_W-1:0]     oIndex
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRIES);

    state_e           state_q;
    logic [15:0]      delay_q;
    logic [19:0]      timeout_q;
    logic [7:0]       retry_q;
    logic             valid_q;
    logic [7:0]       reg_q;
    logic [7:0]       data_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [IDX_W-1:0] index_q;

    logic [IDX_W-1:0] rom_idx;
    logic [15:0]      rom_entry;

    // NEXT loads the following entry's payload directly, so look one index ahead there
    always_comb begin
        rom_idx = index_q;
        if (state_q == StNext) begin
            rom_idx = index_q + 4'd1;
        end
    end

    dvi_tx_cfg_rom u_rom (
        .idx_i   (rom_idx),
        .entry_o (rom_entry)
    );

    // Sequencer FSM with delay/timeout/retry counters and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= StIdle;
            delay_q   <= '0;
            timeout_q <= '0;
            retry_q   <= '0;
            valid_q   <= 1'b0;
            reg_q     <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            index_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone, StFail: begin
                    if (iStart) begin
                        state_q <= StDelay;
                        delay_q <= STARTUP_DELAY;
                        index_q <= '0;
                        retry_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                StDelay: begin
                    if (delay_q == '0) begin
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                        reg_q   <= rom_entry[15:8];
                        data_q  <= rom_entry[7:0];
                    end else begin
                        delay_q <= delay_q - 16'd1;
                    end
                end
                StIssue: begin
                    // Payload held stable until the TWI master accepts
                    if (wr.iWrReady) begin
                        state_q   <= StWait;
                        valid_q   <= 1'b0;
                        timeout_q <= TIMEOUT;
                    end
                end
                StWait: begin
                    if (wr.iWrDone && !wr.iWrNack) begin
                        state_q <= StNext;
                    end else if (wr.iWrDone || (timeout_q == '0)) begin
                        state_q <= StRetry;
                    end else begin
                        timeout_q <= timeout_q - 20'd1;
                    end
                end
                StRetry: begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_q <= retry_q + 8'd1;
                        delay_q <= RETRY_DELAY;
                        state_q <= StDelay;
                    end else begin
                        state_q <= StFail;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                StNext: begin
                    if (index_q == LAST_IDX) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        index_q <= index_q + 4'd1;
                        retry_q <= '0;
                        state_q <= StIssue;
                        valid_q <= 1'b1;
                        reg_q   <= rom_entry[15:8];
                        data_q  <= rom_entry[7:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr.oWrValid   = valid_q;
    assign wr.oWrDevAddr = DEV_ADDR;
    assign wr.oWrRegAddr = reg_q;
    assign wr.oWrData    = data_q;

    assign oBusy  = busy_q;
    assign oDone  = done_q;
    assign oError = error_q;
    assign oIndex = index_q;

endmodule

// File: tb/tb_dvi_tx_config_seq.sv
// Directed bench for dvi_tx_config_seq: reactive TWI slave model plus an expected-transfer queue.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_cmp++; \
        assert ((OBS) === (EXP)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_dvi_tx_config_seq;
    import dvi_tx_cfg_pkg::*;

    logic             clk = 1'b0;
    logic             iRst;
    logic             iStart;
    logic             oBusy;
    logic             oDone;
    logic             oError;
    logic [IDX_W-1:0] oIndex;

    dvi_tx_config_seq_if wr_if ();

    dvi_tx_config_seq #(
        .DEV_ADDR      (7'h76),
        .STARTUP_DELAY (16'd10),
        .RETRY_DELAY   (16'd8),
        .TIMEOUT       (20'd50),
        .MAX_RETRIES   (3)
    ) dut (
        .iClk   (clk),
        .iRst   (iRst),
        .iStart (iStart),
        .wr     (wr_if.master),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oError (oError),
        .oIndex (oIndex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];

    // Slave model configuration / observation
    int         done_cnt = 0;
    int         stray_cnt = 0;
    logic       pend_nack = 1'b0;
    int         nack_left = 0;
    logic [7:0] nack_reg = 8'h00;
    int         silent_left = 0;
    int         bp_left = 0;
    logic       bp_active = 1'b0;
    int         stall_seen = 0;
    int         n_xfer = 0;
    int         n33 = 0;
    logic       valid_prev = 1'b0;
    int         rise_cyc = 0;
    int         nack_edge = 0;
    logic       nack_watch = 1'b0;
    int         nack_gap = -1;
    int         to_accept = 0;
    logic       to_watch = 1'b0;
    int         to_gap = -1;
    logic       both_seen = 1'b0;

    // TWI slave: drives ready/done at negedge; a transfer happens at the next posedge
    // whenever valid and the ready just driven are both high.
    always @(negedge clk) begin : slave_model
        logic        rdy;
        logic [15:0] exp_v;
        rdy = 1'b1;
        wr_if.iWrDone = 1'b0;
        wr_if.iWrNack = 1'b0;
        if (oDone && oError) both_seen = 1'b1;
        if (iRst) begin
            done_cnt  = 0;
            stray_cnt = 0;
            bp_active = 1'b0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    wr_if.iWrDone = 1'b1;
                    wr_if.iWrNack = pend_nack;
                    if (pend_nack) begin
                        nack_edge  = cyc + 1;
                        nack_watch = 1'b1;
                    end
                end
            end
            if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) wr_if.iWrDone = 1'b1;
            end
            if (wr_if.oWrValid && !valid_prev) rise_cyc = cyc;
            if (bp_left > 0 && (bp_active || (wr_if.oWrValid && wr_if.oWrRegAddr == 8'h33))) begin
                bp_active = 1'b1;
                rdy = 1'b0;
                bp_left--;
                stall_seen++;
                `CHK("bp_valid", wr_if.oWrValid, 1'b1)
                `CHK("bp_reg", wr_if.oWrRegAddr, 8'h33)
                `CHK("bp_data", wr_if.oWrData, 8'h08)
                if (bp_left == 0) bp_active = 1'b0;
            end
            if (wr_if.oWrValid && rdy) begin
                n_xfer++;
                if (wr_if.oWrRegAddr == 8'h33) n33++;
                `CHK("dev_addr", wr_if.oWrDevAddr, 7'h76)
                if (nack_watch) begin
                    nack_gap   = rise_cyc - nack_edge;
                    nack_watch = 1'b0;
                end
                if (to_watch) begin
                    to_gap   = rise_cyc - to_accept;
                    to_watch = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL xfer_unexpected: observed %h%h expected none",
                           wr_if.oWrRegAddr, wr_if.oWrData);
                end else begin
                    exp_v = exp_q.pop_front();
                    `CHK("xfer_payload", {wr_if.oWrRegAddr, wr_if.oWrData}, exp_v)
                end
                if (silent_left > 0 && wr_if.oWrRegAddr == 8'h49) begin
                    // No response; stray done lands while the DUT sits in the retry delay
                    silent_left--;
                    stray_cnt = 55;
                    to_accept = cyc + 1;
                    to_watch  = 1'b1;
                end else begin
                    done_cnt  = 5;
                    pend_nack = (nack_left > 0) && (wr_if.oWrRegAddr == nack_reg);
                    if (pend_nack) nack_left--;
                end
            end
        end
        wr_if.iWrReady = rdy;
        valid_prev = wr_if.oWrValid;
    end

    task automatic push_all();
        logic [15:0] tbl [5];
        tbl = '{16'h49C0, 16'h2109, 16'h3308, 16'h3416, 16'h3660};
        for (int i = 0; i < 5; i++) exp_q.push_back(tbl[i]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // sel: 0 oDone, 1 oError, 2 oWrValid, 3 expected queue drained
    task automatic wait_for(input int sel, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = oDone;
                1:       hit = oError;
                2:       hit = wr_if.oWrValid;
                default: hit = (exp_q.size() == 0);
            endcase
        end
        `CHK(tag, hit, 1'b1)
    endtask

    task automatic check_reset_outputs();
        `CHK("rst_valid", wr_if.oWrValid, 1'b0)
        `CHK("rst_busy", oBusy, 1'b0)
        `CHK("rst_done", oDone, 1'b0)
        `CHK("rst_error", oError, 1'b0)
        `CHK("rst_index", oIndex, 4'd0)
        `CHK("rst_regaddr", wr_if.oWrRegAddr, 8'h00)
        `CHK("rst_data", wr_if.oWrData, 8'h00)
    endtask

    initial begin
        int c0;
        int vcount;
        iRst   = 1'b1;
        iStart = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        iRst = 1'b0;

        // Normal run with start latency
        push_all();
        n_xfer = 0;
        @(negedge clk);
        iStart = 1'b1;
        c0 = cyc;
        @(negedge clk);
        iStart = 1'b0;
        wait_for(2, 100, "first_valid_seen");
        `CHK("start_latency", cyc - c0 - 1, 11)
        wait_for(0, 2000, "normal_done");
        `CHK("normal_busy", oBusy, 1'b0)
        `CHK("normal_error", oError, 1'b0)
        `CHK("normal_xfers", n_xfer, 5)
        `CHK("normal_q_empty", exp_q.size(), 0)

        // Restart from DONE with backpressure on entry 2 and a start pulse mid-sequence
        push_all();
        n_xfer = 0;
        n33 = 0;
        stall_seen = 0;
        bp_left = 20;
        @(negedge clk);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        `CHK("restart_done_clr", oDone, 1'b0)
        `CHK("restart_busy", oBusy, 1'b1)
        wait_for(2, 100, "bp_first_valid");
        repeat (2) @(negedge clk);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        wait_for(0, 2000, "bp_done");
        `CHK("bp_stall_cycles", stall_seen, 20)
        `CHK("bp_entry2_xfers", n33, 1)
        `CHK("bp_xfers", n_xfer, 5)

        // Single NACK on entry 1
        exp_q = '{16'h49C0, 16'h2109, 16'h2109, 16'h3308, 16'h3416, 16'h3660};
        n_xfer = 0;
        nack_reg = 8'h21;
        nack_left = 1;
        pulse_start();
        wait_for(0, 2000, "nack1_done");
        `CHK("nack1_retry_gap", nack_gap, 10)
        `CHK("nack1_xfers", n_xfer, 6)
        `CHK("nack1_error", oError, 1'b0)

        // Persistent NACK on entry 3
        exp_q = '{16'h49C0, 16'h2109, 16'h3308, 16'h3416, 16'h3416, 16'h3416, 16'h3416};
        n_xfer = 0;
        nack_reg = 8'h34;
        nack_left = 100;
        pulse_start();
        wait_for(1, 3000, "fail_error");
        `CHK("fail_index", oIndex, 4'd3)
        `CHK("fail_done", oDone, 1'b0)
        `CHK("fail_busy", oBusy, 1'b0)
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wr_if.oWrValid) vcount++;
        end
        `CHK("fail_no_valid", vcount, 0)
        `CHK("fail_xfers", n_xfer, 7)
        nack_left = 0;

        // Timeout on entry 0 with a stray done during the retry delay
        exp_q = '{16'h49C0, 16'h49C0, 16'h2109, 16'h3308, 16'h3416, 16'h3660};
        n_xfer = 0;
        silent_left = 1;
        @(negedge clk);
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        `CHK("restart_err_clr", oError, 1'b0)
        wait_for(0, 3000, "timeout_done");
        `CHK("timeout_retry_gap", to_gap, 61)
        `CHK("timeout_xfers", n_xfer, 6)

        // Reset while waiting on entry 2
        exp_q = '{16'h49C0, 16'h2109, 16'h3308};
        pulse_start();
        wait_for(3, 2000, "pre_reset_reach");
        @(negedge clk);
        iRst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        iRst = 1'b0;

        // Replay from entry 0 after reset
        push_all();
        n_xfer = 0;
        pulse_start();
        wait_for(0, 2000, "replay_done");
        `CHK("replay_xfers", n_xfer, 5)
        `CHK("replay_q_empty", exp_q.size(), 0)
        `CHK("done_error_exclusive", both_seen, 1'b0)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
